// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: FSM states, instruction frame layout, ALU opcodes and frame decode
package alu_sequencer_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_WB, S_PAUSE, S_DONE} state_t;
   localparam int FRAME_BITS = 13;
   localparam int OPND_W     = 4;
   localparam int OP_W       = 4;
   localparam int A_LSB      = 9;
   localparam int B_LSB      = 5;
   localparam int CIN_BIT    = 4;
   localparam int OP_LSB     = 0;
   localparam logic [OP_W-1:0] OP_PASS = 4'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
   localparam logic [OP_W-1:0] OP_AND  = 4'd3;
   localparam logic [OP_W-1:0] OP_OR   = 4'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic              cin;
      logic [OP_W-1:0]   op;
   } instr_t;
   function automatic instr_t frame_decode(input logic [FRAME_BITS-1:0] f);
      frame_decode.a   = f[A_LSB +: OPND_W];
      frame_decode.b   = f[B_LSB +: OPND_W];
      frame_decode.cin = f[CIN_BIT];
      frame_decode.op  = f[OP_LSB +: OP_W];
   endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches ROM frames 0..PROG_LEN-1, drives the ALU and reports each result
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 3,
   parameter int FRAME_W  = 13,
   parameter int DATA_W   = 4,
   parameter int PROG_LEN = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               step_mode,
   input  logic               step,
   input  logic               abort,
   output logic               mem_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [FRAME_W-1:0] mem_frame,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic               alu_cin,
   output logic [3:0]         alu_op,
   input  logic [DATA_W:0]    alu_y,
   output logic [DATA_W:0]    result,
   output logic [ADDR_W-1:0]  result_pc,
   output logic               result_valid,
   output logic               busy,
   output logic               done
);
   state_t state, nxt;
   logic [ADDR_W-1:0] pc;
   instr_t instr;
   logic last;
   assign last = pc == ADDR_W'(PROG_LEN - 1);
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = start ? S_FETCH : S_IDLE;
         S_FETCH: nxt = S_LOAD;
         S_LOAD:  nxt = S_EXEC;
         S_EXEC:  nxt = S_WB;
         S_WB:    nxt = last ? S_DONE : step_mode ? S_PAUSE : S_FETCH;
         S_PAUSE: nxt = step ? S_FETCH : S_PAUSE;
         default: nxt = S_IDLE;
      endcase
      if (abort && state != S_IDLE) nxt = S_IDLE;
   end
   // every return to IDLE (abort or completion) rewinds pc and blanks the ALU operands
   always_ff @(posedge clk)
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         instr     <= '0;
         result    <= '0;
         result_pc <= '0;
      end else begin
         state <= nxt;
         if (state == S_LOAD) instr <= frame_decode(mem_frame);
         if (state == S_EXEC && !abort) begin
            result    <= alu_y;
            result_pc <= pc;
         end
         if (state == S_WB && !last) pc <= pc + 1'b1;
         if (nxt == S_IDLE) begin
            pc    <= '0;
            instr <= '0;
         end
      end
   assign mem_en       = state == S_FETCH;
   assign mem_addr     = pc;
   assign alu_a        = instr.a;
   assign alu_b        = instr.b;
   assign alu_cin      = instr.cin;
   assign alu_op       = instr.op;
   assign result_valid = state == S_WB && !abort;
   assign done         = state == S_DONE && !abort;
   assign busy         = state != S_IDLE;
endmodule
